// File: rtl/wb_pkg_hdl.sv
// wb_pkg_hdl: shared Wishbone HDL types and limits.
package wb_pkg_hdl;
   typedef enum logic [1:0] {IDLE, WAIT, TERM, GAP} wb_resp_state_t;
   localparam int WB_RESP_MAX_WAIT = 15;
endpackage

// File: rtl/wb_mem_responder_if.sv
// wb_mem_responder_if: Wishbone classic-cycle bus between an initiator and a responder.
interface wb_mem_responder_if #(
   parameter int WB_ADDR_WIDTH = 32,
   parameter int WB_DATA_WIDTH = 16
);
   logic cyc;
   logic stb;
   logic we;
   logic [WB_ADDR_WIDTH-1:0] adr;
   logic [WB_DATA_WIDTH-1:0] dout;
   logic [WB_DATA_WIDTH/8-1:0] sel;
   logic [WB_DATA_WIDTH-1:0] din;
   logic ack;
   logic err;
   logic rty;
   logic inta;
   modport master (output cyc, stb, we, adr, dout, sel, input din, ack, err, rty, inta);
   modport slave (input cyc, stb, we, adr, dout, sel, output din, ack, err, rty, inta);
endinterface

// File: rtl/wb_resp_mem.sv
// wb_resp_mem: single-port RAM with per-byte write enable and a registered read
// that returns zero whenever no read is requested.
module wb_resp_mem #(
   parameter int DEPTH = 256,
   parameter int WIDTH = 16,
   localparam int MAW = $clog2(DEPTH),
   localparam int NB = WIDTH / 8
) (
   input  logic             clk,
   input  logic             rd,
   input  logic [NB-1:0]    be,
   input  logic [MAW-1:0]   addr,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata
);
   logic [WIDTH-1:0] mem [DEPTH];
   always_ff @(posedge clk) begin
      rdata <= rd ? mem[addr] : '0;
      for (int k = 0; k < NB; k++)
         if (be[k]) mem[addr][8*k +: 8] <= wdata[8*k +: 8];
   end
endmodule

// File: rtl/wb_mem_responder.sv
// wb_mem_responder: Wishbone classic responder over a byte-writable word memory
// with wait states, out-of-range error, cyc-drop abort and a doorbell interrupt.
module wb_mem_responder
   import wb_pkg_hdl::*;
#(
   parameter int WB_ADDR_WIDTH = 32,
   parameter int WB_DATA_WIDTH = 16,
   parameter int DEPTH = 256,
   parameter int WAIT_STATES = 1
) (
   input logic clk,
   input logic rst,
   wb_mem_responder_if.slave bus
);
   localparam int MAW = $clog2(DEPTH);
   localparam int NB = WB_DATA_WIDTH / 8;
   localparam logic [WB_ADDR_WIDTH:0] LIMIT = (WB_ADDR_WIDTH+1)'(DEPTH);
   localparam logic [WB_ADDR_WIDTH-1:0] BELL = WB_ADDR_WIDTH'(DEPTH - 1);
   localparam logic [3:0] LAST = 4'(WAIT_STATES - 1);
   if (WAIT_STATES < 0 || WAIT_STATES > WB_RESP_MAX_WAIT) begin : g_bad_wait
      $error("WAIT_STATES out of range");
   end
   if (WB_DATA_WIDTH % 8 != 0) begin : g_bad_width
      $error("WB_DATA_WIDTH must be a multiple of 8");
   end
   wb_resp_state_t state;
   logic [3:0] cnt;
   logic [WB_ADDR_WIDTH-1:0] adr_q;
   logic [WB_DATA_WIDTH-1:0] dout_q;
   logic [NB-1:0] sel_q;
   logic we_q;
   logic ack;
   logic err;
   logic inta;
   logic [WB_ADDR_WIDTH-1:0] cur_adr;
   logic cur_we;
   logic hit;
   logic go;
   logic rd;
   // In IDLE the request is still on the bus, so zero-wait accesses decode it directly.
   always_comb begin
      cur_adr = state == IDLE ? bus.adr : adr_q;
      cur_we = state == IDLE ? bus.we : we_q;
      hit = {1'b0, cur_adr} < LIMIT;
      go = state == IDLE ? bus.cyc && bus.stb && WAIT_STATES == 0
                         : state == WAIT && bus.cyc && cnt == LAST;
      rd = !rst && go && hit && !cur_we;
   end
   wb_resp_mem #(.DEPTH(DEPTH), .WIDTH(WB_DATA_WIDTH)) u_mem (
      .clk(clk),
      .rd(rd),
      .be(sel_q & {NB{ack && we_q && !rst}}),
      .addr(cur_adr[MAW-1:0]),
      .wdata(dout_q),
      .rdata(bus.din)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt <= '0;
         ack <= 1'b0;
         err <= 1'b0;
         inta <= 1'b0;
      end else begin
         ack <= go && hit;
         err <= go && !hit;
         if (ack && adr_q == BELL) inta <= we_q ? inta | (|sel_q) : 1'b0;
         case (state)
            IDLE: if (bus.cyc && bus.stb) begin
               adr_q <= bus.adr;
               we_q <= bus.we;
               dout_q <= bus.dout;
               sel_q <= bus.sel;
               cnt <= '0;
               state <= WAIT_STATES == 0 ? TERM : WAIT;
            end
            WAIT: if (!bus.cyc) state <= IDLE;
               else if (cnt == LAST) state <= TERM;
               else cnt <= cnt + 4'd1;
            TERM: state <= GAP;
            default: state <= IDLE;
         endcase
      end
   end
   assign bus.ack = ack;
   assign bus.err = err;
   assign bus.inta = inta;
   assign bus.rty = 1'b0;
endmodule

// File: tb/tb_wb_mem_responder.sv
// tb_wb_mem_responder: randomized check of two responders (1 and 3 wait states)
// against a word-array model of memory and doorbell.
module tb_wb_mem_responder;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   logic cyc = 1'b0, stb = 1'b0, we = 1'b0, dsel = 1'b0;
   logic [31:0] adr = '0;
   logic [15:0] dout = '0;
   logic [1:0] sel = '0;
   wb_mem_responder_if #(.WB_ADDR_WIDTH(32), .WB_DATA_WIDTH(16)) b1 ();
   wb_mem_responder_if #(.WB_ADDR_WIDTH(32), .WB_DATA_WIDTH(16)) b3 ();
   wb_mem_responder #(.WAIT_STATES(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
   wb_mem_responder #(.WAIT_STATES(3)) u3 (.clk(clk), .rst(rst), .bus(b3));
   assign b1.cyc = cyc & ~dsel;
   assign b1.stb = stb & ~dsel;
   assign b3.cyc = cyc & dsel;
   assign b3.stb = stb & dsel;
   assign b1.we = we;
   assign b3.we = we;
   assign b1.adr = adr;
   assign b3.adr = adr;
   assign b1.dout = dout;
   assign b3.dout = dout;
   assign b1.sel = sel;
   assign b3.sel = sel;
   logic o_ack, o_err, o_inta;
   logic [15:0] o_din;
   assign o_ack = dsel ? b3.ack : b1.ack;
   assign o_err = dsel ? b3.err : b1.err;
   assign o_inta = dsel ? b3.inta : b1.inta;
   assign o_din = dsel ? b3.din : b1.din;
   logic [15:0] m [2][256];
   bit bell [2];
   int nvec = 0, nerr = 0;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic acc(input bit d, input logic w, input logic [31:0] a, input logic [15:0] v, input logic [1:0] s);
      int ws;
      bit ok;
      bit hold;
      logic [15:0] e;
      ws = d ? 3 : 1;
      ok = a < 256;
      hold = 1'($urandom_range(0, 1));
      e = (ok && !w) ? m[d][a[7:0]] : 16'h0;
      tick();
      dsel = d; cyc = 1; stb = 1; we = w; adr = a; dout = v; sel = s;
      tick();
      adr = $urandom; dout = 16'($urandom); sel = 2'($urandom); we = ~w;
      for (int c = 1; c <= ws; c++) begin
         chk("wait_ack", o_ack, 0);
         chk("wait_err", o_err, 0);
         tick();
      end
      chk("term_ack", o_ack, 32'(ok));
      chk("term_err", o_err, 32'(!ok));
      chk("term_din", o_din, e);
      if (ok && w)
         for (int k = 0; k < 2; k++) if (s[k]) m[d][a[7:0]][8*k +: 8] = v[8*k +: 8];
      if (ok && a == 255) bell[d] = w ? bell[d] | (|s) : 1'b0;
      if (!hold) begin cyc = 0; stb = 0; end
      tick();
      chk("gap_ack", o_ack, 0);
      chk("gap_err", o_err, 0);
      chk("gap_din", o_din, 0);
      chk("inta", o_inta, 32'(bell[d]));
   endtask
   task automatic abort(input bit d, input logic w, input logic [31:0] a, input logic [15:0] v, input logic [1:0] s, input int drop);
      tick();
      dsel = d; cyc = 1; stb = 1; we = w; adr = a; dout = v; sel = s;
      tick();
      for (int c = 1; c <= (d ? 3 : 1) + 2; c++) begin
         if (c == drop) begin cyc = 0; stb = 0; end
         chk("abort_ack", o_ack, 0);
         chk("abort_err", o_err, 0);
         chk("abort_inta", o_inta, 32'(bell[d]));
         tick();
      end
      cyc = 0; stb = 0;
   endtask
   initial begin
      tick(); tick();
      chk("rst_ack1", b1.ack, 0); chk("rst_err1", b1.err, 0); chk("rst_din1", b1.din, 0);
      chk("rst_rty1", b1.rty, 0); chk("rst_inta1", b1.inta, 0);
      chk("rst_ack3", b3.ack, 0); chk("rst_rty3", b3.rty, 0); chk("rst_inta3", b3.inta, 0);
      rst = 0;
      for (int d = 0; d < 2; d++)
         for (int a = 0; a < 256; a++) acc(1'(d), 1, 32'(a), 16'($urandom), 2'b11);
      acc(0, 1, 'h10, 'hA5C3, 2'b11);
      acc(0, 0, 'h10, 'h0, 2'b11);
      acc(0, 1, 'h20, 'hFFFF, 2'b11);
      acc(0, 1, 'h20, 'h0012, 2'b01);
      acc(0, 0, 'h20, 'h0, 2'b00);
      acc(0, 1, 'h20, 'h5555, 2'b00);
      acc(0, 0, 'h20, 'h0, 2'b11);
      acc(0, 0, 'h100, 'h0, 2'b11);
      acc(0, 0, 'h0, 'h0, 2'b11);
      acc(0, 1, 'hFF, 'h0001, 2'b11);
      abort(0, 0, 'hFF, 'h0, 2'b11, 1);
      acc(0, 0, 'hFF, 'h0, 2'b11);
      acc(1, 1, 'h40, 'h1234, 2'b11);
      abort(1, 1, 'h40, 'hBEEF, 2'b11, 2);
      acc(1, 0, 'h40, 'h0, 2'b11);
      acc(0, 1, 'h30, 'h1111, 2'b11);
      acc(0, 1, 'hFF, 'h0002, 2'b10);
      tick();
      dsel = 0; cyc = 1; stb = 1; we = 1; adr = 'h30; dout = 'h2222; sel = 2'b11;
      tick();
      rst = 1;
      tick();
      chk("rstw_ack", b1.ack, 0); chk("rstw_err", b1.err, 0);
      chk("rstw_din", b1.din, 0); chk("rstw_inta", b1.inta, 0);
      rst = 0; cyc = 0; stb = 0; bell[0] = 0; bell[1] = 0;
      acc(0, 0, 'h30, 'h0, 2'b11);
      tick();
      dsel = 0; cyc = 1; stb = 1; we = 1; adr = 'h30; dout = 'h3333; sel = 2'b11;
      tick(); tick();
      chk("rstt_ack", b1.ack, 1);
      rst = 1;
      tick();
      chk("rstt_ack0", b1.ack, 0);
      rst = 0; cyc = 0; stb = 0;
      acc(0, 0, 'h30, 'h0, 2'b11);
      repeat (400) begin
         bit d;
         int r;
         logic [31:0] a;
         d = 1'($urandom_range(0, 1));
         r = int'($urandom_range(0, 9));
         a = r < 2 ? 32'hFF : r == 2 ? 32'($urandom_range(256, 511)) : r == 3 ? $urandom | 32'h100 : 32'($urandom_range(0, 255));
         if ($urandom_range(0, 9) == 0) abort(d, 1'($urandom), a, 16'($urandom), 2'($urandom), int'($urandom_range(1, d ? 3 : 1)));
         else acc(d, 1'($urandom), a, 16'($urandom), 2'($urandom));
      end
      cyc = 0; stb = 0;
      tick();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule

// File: doc/wb_mem_responder.md
# wb_mem_responder

Synthesizable Wishbone classic-cycle responder (slave) backed by a byte-lane-writable word memory. It is the RTL counterpart to our Wishbone initiator BFM. It serves as the default DUT-side endpoint in wb agent benches and as a scratch/register target in subsystem integration. It supports programmable wait states, error termination for out-of-range addresses, cycle abort on `cyc` drop, and a doorbell interrupt.

## Interface
- `WB_ADDR_WIDTH`, 32: address bus width.
- `WB_DATA_WIDTH`, 16: data bus width; must be a multiple of 8.
- `DEPTH`, 256: number of memory words; power of two, ≤ 2^WB_ADDR_WIDTH.
- `WAIT_STATES`, 1: cycles inserted between request acceptance and termination; 0–15.

Ports:
- `clk` input 1: sole clock; all logic on posedge.
- `rst` input 1: reset; synchronous, active-high.
- `cyc` input 1: bus cycle valid.
- `stb` input 1: strobe.
- `we` input 1: 1 = write, 0 = read.
- `adr` input WB_ADDR_WIDTH: word address.
- `dout` input WB_DATA_WIDTH: write data from initiator.
- `sel` input WB_DATA_WIDTH/8: byte-lane enables.
- `din` output WB_DATA_WIDTH: read data to initiator.
- `ack` output 1: normal termination, one-cycle pulse.
- `err` output 1: error termination, one-cycle pulse.
- `rty` output 1: tied 0 (retry unsupported).
- `inta` output 1: doorbell interrupt, level.

## Operation
- FSM states: IDLE, WAIT, TERM, GAP.
- **IDLE**
  - If `cyc & stb` is sampled high, latch `adr`, `we`, `dout`, `sel`.
  - Go to WAIT if WAIT_STATES > 0; otherwise go to TERM.
- **WAIT**
  - A counter counts WAIT_STATES cycles, then the FSM goes to TERM.
  - If `cyc` is sampled low in WAIT, abort: return to IDLE with no write, no `ack`/`err`, and no `inta` change.
- **TERM**
  - Assert exactly one of `ack` or `err` for one cycle, then go to GAP.
  - `err` fires when the latched `adr >= DEPTH`. In that case no memory access occurs and `din` = 0.
  - Otherwise `ack` fires.
    - Read: `din` = mem[adr] during the `ack` cycle.
    - Write: mem[adr] byte lane k is updated where `sel[k]`=1, committed on the clock edge ending TERM.
  - A write with `sel` = 0 is still acked and leaves memory unchanged.
- **GAP**
  - One idle cycle with `ack`/`err` low and the request ignored; then return to IDLE.
  - This absorbs the initiator dropping `stb` one cycle after it samples `ack`.
- **Doorbell**
  - An acked write to address DEPTH-1 with any `sel` bit set sets `inta` on the next edge.
  - An acked read of address DEPTH-1 clears `inta`.
  - Set wins if both occur in the same cycle; they cannot, since only one access completes at a time.
- **Latched request:** `adr`, `we`, `dout` and `sel` changing after acceptance has no effect.
- **Memory reset:** memory contents are not reset; contents are undefined until written.

## Timing
- Reset values: `din`=0, `ack`=0, `err`=0, `rty`=0, `inta`=0; FSM in IDLE; wait counter 0.
- Reset asserted in any state forces these values on the next edge. An in-flight write is dropped, not committed.
- Latency: request sampled at edge N; `ack`/`err` is high during cycle N+1+WAIT_STATES.
- Throughput: with WAIT_STATES=0, back-to-back accesses complete every 3 cycles (IDLE, TERM, GAP).
- `din` is registered and holds 0 outside the `ack` cycle of a read.
- `inta` changes one edge after the terminating cycle.

## Structure
- Add to `wb_pkg_hdl`:
  - typedef `wb_resp_state_t` (IDLE, WAIT, TERM, GAP);
  - constant `WB_RESP_MAX_WAIT` = 15.
- Sub-module `wb_resp_mem`: single-port synchronous RAM, DEPTH × WB_DATA_WIDTH, per-byte write enable, registered read.
- The FSM, request latch and doorbell logic live in the top module.

## Test plan
- Reset, then write adr=0x10, data=0xA5C3, sel=2'b11; then read adr=0x10 → `ack` 2 cycles after each request (WAIT_STATES=1); read `din`=0xA5C3.
- Write 0xFFFF to adr=0x20, then write 0x0012 with sel=2'b01, then read → `din`=0xFF12.
- Read adr=0x100 (DEPTH=256) → `err` pulse for one cycle, `ack` stays 0, `din`=0; a following read of adr=0 completes normally.
- Write 0x1 to adr=0xFF → `inta`=1 one edge after `ack`; read adr=0xFF → `din`=0x0001 and `inta`=0 one edge later.
- WAIT_STATES=3: drop `cyc` 2 cycles after the request → no `ack`/`err`, FSM back in IDLE; a subsequent read of the same address returns its old value.
- Assert `rst` during WAIT of a write to adr=0x30 (previously holding 0x1111) → all outputs 0 next edge; a read after reset returns 0x1111.
